// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the recorder audio path.
//   sample_t      signed 8-bit audio sample
//   SAMPLE_MAX/MIN saturation limits for sample_t
//   sat_result_t  saturated sample plus clip flag
//   log2_ceil     elaboration-time log2 for sizing counters
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  localparam int SAMPLE_MAX = 127;
  localparam int SAMPLE_MIN = -128;

  typedef struct packed {
    logic    clip;
    sample_t sample;
  } sat_result_t;

  // Smallest r with 2**r >= value
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: divides clk_i down to the PDM microphone clock and marks the
// last system cycle of each mic clock period.
//   clk_i, rst_i   system clock, async active-high reset
//   enable_i       run; low clears the divider and parks mic_clk_o low
//   mic_clk_o      registered mic clock, high for the first half of the period
//   pdm_tick_c_o   combinational one-cycle strobe at div_cnt == CLK_DIV-1
module pdm_clk_gen #(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic mic_clk_o,
  output logic pdm_tick_c_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             mic_clk_q, mic_clk_d;

  assign pdm_tick_c_o = enable_i && (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign mic_clk_o    = mic_clk_q;

  // Next divider value; mic clock is decoded from it so it lines up with div_cnt_q
  always_comb begin
    div_cnt_d = '0;
    mic_clk_d = 1'b0;
    if (enable_i) begin
      div_cnt_d = pdm_tick_c_o ? '0 : div_cnt_q + CNT_W'(1);
      mic_clk_d = (div_cnt_d < CNT_W'(HALF));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mic_clk_q <= mic_clk_d;
    end
  end

endmodule

// File: rtl/pdm_mic_frontend.sv
// pdm_mic_frontend: PDM microphone front end. Generates the mic clock,
// synchronises the PDM bit, boxcar-decimates it and emits a gained,
// saturated signed 8-bit sample with a one-cycle strobe.
//   clk_in, rst_in   system clock, async active-high reset
//   enable_in        run/stop capture (low discards the current window)
//   gain_in          extra left shift 0..3 after centring
//   mic_data_in      raw asynchronous PDM data
//   mic_clk_out      PDM clock to the microphone
//   audio_out        signed sample, held between strobes
//   audio_valid_out  one-cycle strobe for a new audio_out
//   clip_out         high on the strobe cycle when the sample saturated
module pdm_mic_frontend
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 32,
  parameter int unsigned DECIMATION = 64,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 enable_in,
  input  logic [1:0]           gain_in,
  input  logic                 mic_data_in,
  output logic                 mic_clk_out,
  output logic [OUT_WIDTH-1:0] audio_out,
  output logic                 audio_valid_out,
  output logic                 clip_out
);

  localparam int unsigned LOG2_DEC   = log2_ceil(DECIMATION);
  localparam int unsigned BIT_W      = LOG2_DEC;
  localparam int unsigned ACC_W      = LOG2_DEC + 1;
  localparam int unsigned CALC_W     = 16;
  // 7 - log2(DECIMATION/2): maps a full-scale window onto +-128
  localparam int unsigned BASE_SHIFT = 8 - LOG2_DEC;

  logic              pdm_tick_c;
  logic [1:0]        sync_q;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]  ones_acc_q, ones_acc_d;
  sample_t           audio_q, audio_d;
  logic              valid_q, valid_d;
  logic              clip_q, clip_d;

  logic              close_c;
  logic [ACC_W-1:0]  sum_c;
  logic signed [CALC_W-1:0] centred_c;
  logic signed [CALC_W-1:0] scaled_c;
  logic [3:0]        shamt_c;
  sat_result_t       sat_c;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .enable_i     (enable_in),
    .mic_clk_o    (mic_clk_out),
    .pdm_tick_c_o (pdm_tick_c)
  );

  // Window arithmetic: the closing tick's bit belongs to the closing window
  always_comb begin
    close_c   = pdm_tick_c && (bit_cnt_q == BIT_W'(DECIMATION - 1));
    sum_c     = ones_acc_q + ACC_W'(sync_q[1]);
    centred_c = $signed(CALC_W'(sum_c)) - $signed(CALC_W'(DECIMATION / 2));
    shamt_c   = 4'(BASE_SHIFT) + 4'(gain_in);
    scaled_c  = centred_c <<< shamt_c;
    sat_c.clip   = 1'b0;
    sat_c.sample = scaled_c[7:0];
    if (scaled_c > CALC_W'(SAMPLE_MAX)) begin
      sat_c.clip   = 1'b1;
      sat_c.sample = sample_t'(SAMPLE_MAX);
    end else if (scaled_c < CALC_W'(SAMPLE_MIN)) begin
      sat_c.clip   = 1'b1;
      sat_c.sample = sample_t'(SAMPLE_MIN);
    end
  end

  // Accumulator and output next-state
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    ones_acc_d = ones_acc_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    clip_d     = 1'b0;
    if (!enable_in) begin
      bit_cnt_d  = '0;
      ones_acc_d = '0;
    end else if (pdm_tick_c) begin
      if (close_c) begin
        bit_cnt_d  = '0;
        ones_acc_d = '0;
        audio_d    = sat_c.sample;
        clip_d     = sat_c.clip;
        valid_d    = 1'b1;
      end else begin
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        ones_acc_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q     <= '0;
      bit_cnt_q  <= '0;
      ones_acc_q <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], mic_data_in};
      bit_cnt_q  <= bit_cnt_d;
      ones_acc_q <= ones_acc_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
    end
  end

  assign audio_out       = audio_q;
  assign audio_valid_out = valid_q;
  assign clip_out        = clip_q;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Directed bench for pdm_mic_frontend at default parameters.
module tb_pdm_mic_frontend;

  localparam int WIN = 32 * 64;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       enable_in;
  logic [1:0] gain_in;
  logic       mic_data_in;
  logic       mic_clk_out;
  logic [7:0] audio_out;
  logic       audio_valid_out;
  logic       clip_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int win_idx = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int tick_since = 0;
  int strobe_ticks = 0;
  logic [7:0] strobe_audio = '0;
  logic       strobe_clip = 1'b0;

  pdm_mic_frontend dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .gain_in         (gain_in),
    .mic_data_in     (mic_data_in),
    .mic_clk_out     (mic_clk_out),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .clip_out        (clip_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Strobe and tick monitor, sampled away from the active edge
  always @(negedge clk_in) begin
    if (rst_in || !enable_in) tick_since = 0;
    else if (dut.u_clk_gen.pdm_tick_c_o) tick_since++;
    if (audio_valid_out) begin
      strobe_cnt++;
      strobe_cyc   = cyc;
      strobe_audio = audio_out;
      strobe_clip  = clip_out;
      strobe_ticks = tick_since;
      tick_since   = 0;
    end
  end

  function automatic logic pattern(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      default: return k < 40;
    endcase
  endfunction

  task automatic start_capture();
    @(negedge clk_in);
    enable_in = 1'b1;
    e0 = cyc;
    win_idx = 0;
  endtask

  task automatic stop_capture();
    @(negedge clk_in);
    enable_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  // Drive nwin full windows and check each resulting strobe
  task automatic run_windows(input int mode, input logic [1:0] gain, input int nwin,
                             input int exp_audio, input logic exp_clip, input string name);
    int base;
    gain_in = gain;
    for (int w = 0; w < nwin; w++) begin
      base = strobe_cnt;
      for (int k = 0; k < 64; k++) begin
        mic_data_in = pattern(mode, k);
        repeat (32) @(negedge clk_in);
      end
      #1;
      win_idx++;
      checks++;
      if (strobe_cnt !== base + 1) begin
        errors++;
        $display("FAIL %s strobe_count: got %0d required 1", name, strobe_cnt - base);
      end
      checks++;
      if (strobe_cyc !== e0 + win_idx * WIN) begin
        errors++;
        $display("FAIL %s strobe_time: got %0d required %0d", name, strobe_cyc - e0, win_idx * WIN);
      end
      checks++;
      if (int'($signed(strobe_audio)) !== exp_audio) begin
        errors++;
        $display("FAIL %s audio: got %0d required %0d", name, $signed(strobe_audio), exp_audio);
      end
      checks++;
      if (strobe_clip !== exp_clip) begin
        errors++;
        $display("FAIL %s clip: got %0b required %0b", name, strobe_clip, exp_clip);
      end
      checks++;
      if (strobe_ticks !== 64) begin
        errors++;
        $display("FAIL %s ticks_per_strobe: got %0d required 64", name, strobe_ticks);
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    enable_in = 1'b0;
    gain_in = 2'd0;
    mic_data_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (audio_out !== 8'd0) begin errors++; $display("FAIL reset audio: got %0d required 0", audio_out); end
    checks++;
    if (audio_valid_out !== 1'b0) begin errors++; $display("FAIL reset valid: got %0b required 0", audio_valid_out); end
    checks++;
    if (clip_out !== 1'b0) begin errors++; $display("FAIL reset clip: got %0b required 0", clip_out); end
    checks++;
    if (mic_clk_out !== 1'b0) begin errors++; $display("FAIL reset mic_clk: got %0b required 0", mic_clk_out); end
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_mic_clk();
    logic s [0:95];
    int r1, r2, highs;
    r1 = -1;
    r2 = -1;
    highs = 0;
    start_capture();
    for (int i = 0; i < 96; i++) begin
      @(negedge clk_in);
      s[i] = mic_clk_out;
    end
    for (int i = 1; i < 96; i++) begin
      if (s[i] && !s[i-1]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    end
    if (r1 >= 0 && r1 + 31 < 96) begin
      for (int i = r1; i < r1 + 32; i++) if (s[i]) highs++;
    end
    checks++;
    if (r2 - r1 !== 32) begin errors++; $display("FAIL mic_clk period: got %0d required 32", r2 - r1); end
    checks++;
    if (highs !== 16) begin errors++; $display("FAIL mic_clk high_cycles: got %0d required 16", highs); end
    stop_capture();
    checks++;
    if (mic_clk_out !== 1'b0) begin errors++; $display("FAIL mic_clk stopped: got %0b required 0", mic_clk_out); end
  endtask

  task automatic test_constant();
    start_capture();
    run_windows(0, 2'd0, 3, -128, 1'b0, "zeros_g0");
    run_windows(0, 2'd3, 1, -128, 1'b1, "zeros_g3");
    run_windows(1, 2'd0, 2, 127, 1'b1, "ones_g0");
    stop_capture();
  endtask

  task automatic test_alternating();
    start_capture();
    for (int g = 0; g < 4; g++) run_windows(2, 2'(g), 1, 0, 1'b0, "alternating");
    stop_capture();
  endtask

  task automatic test_40_24();
    start_capture();
    run_windows(3, 2'd0, 1, 32, 1'b0, "p40_g0");
    run_windows(3, 2'd1, 1, 64, 1'b0, "p40_g1");
    run_windows(3, 2'd2, 1, 127, 1'b1, "p40_g2");
    stop_capture();
  endtask

  task automatic test_disable_midwindow();
    int base;
    logic clk_seen;
    clk_seen = 1'b0;
    start_capture();
    run_windows(1, 2'd0, 1, 127, 1'b1, "pre_disable");
    for (int k = 0; k < 30; k++) begin
      mic_data_in = 1'b1;
      repeat (32) @(negedge clk_in);
    end
    enable_in = 1'b0;
    base = strobe_cnt;
    repeat (500) begin
      @(negedge clk_in);
      if (mic_clk_out) clk_seen = 1'b1;
    end
    checks++;
    if (strobe_cnt !== base) begin errors++; $display("FAIL disabled strobes: got %0d required 0", strobe_cnt - base); end
    checks++;
    if (int'($signed(audio_out)) !== 127) begin errors++; $display("FAIL disabled audio_hold: got %0d required 127", $signed(audio_out)); end
    checks++;
    if (clk_seen !== 1'b0) begin errors++; $display("FAIL disabled mic_clk: got 1 required 0"); end
    start_capture();
    run_windows(0, 2'd0, 1, -128, 1'b0, "reenable");
    stop_capture();
  endtask

  task automatic test_reset_midwindow();
    start_capture();
    gain_in = 2'd1;
    for (int k = 0; k < 20; k++) begin
      mic_data_in = 1'b1;
      repeat (32) @(negedge clk_in);
    end
    #3 rst_in = 1'b1;
    #1;
    checks++;
    if (audio_out !== 8'd0) begin errors++; $display("FAIL midreset audio: got %0d required 0", $signed(audio_out)); end
    checks++;
    if (mic_clk_out !== 1'b0) begin errors++; $display("FAIL midreset mic_clk: got %0b required 0", mic_clk_out); end
    checks++;
    if (audio_valid_out !== 1'b0 || clip_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset flags: got valid=%0b clip=%0b required 0 0", audio_valid_out, clip_out);
    end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    e0 = cyc;
    win_idx = 0;
    run_windows(3, 2'd1, 1, 64, 1'b0, "after_reset");
    stop_capture();
  endtask

  initial begin
    test_reset();
    test_mic_clk();
    test_constant();
    test_alternating();
    test_40_24();
    test_disable_midwindow();
    test_reset_midwindow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
